parse_big_field_table_a2: RTL and testbench

//   Captures the first FIELD_LEN beats of each AXI-stream frame into a parallel value array (unbounded field

---
 rtl/parse_big_field_table_a2_if.sv | 37 +++
 rtl/parse_big_field_table_a2.sv | 176 +++++++++++++++++
 tb/tb_parse_big_field_table_a2.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parse_big_field_table_a2_if.sv
// AXI-stream bundle shared by the field parser's input and output ports.
// The modports are master (drives the stream) and slaver (receives it); slave is an alias of slaver.
interface axi_stream_inf #(
   parameter int unsigned DSIZE = 8
);
   localparam int unsigned KSIZE = (DSIZE + 7) / 8;

   logic             axis_tvalid;
   logic             axis_tready;
   logic [DSIZE-1:0] axis_tdata;
   logic [KSIZE-1:0] axis_tkeep;
   logic             axis_tlast;

   modport master (
      output axis_tvalid,
      output axis_tdata,
      output axis_tkeep,
      output axis_tlast,
      input  axis_tready
   );

   modport slaver (
      input  axis_tvalid,
      input  axis_tdata,
      input  axis_tkeep,
      input  axis_tlast,
      output axis_tready
   );

   modport slave (
      input  axis_tvalid,
      input  axis_tdata,
      input  axis_tkeep,
      input  axis_tlast,
      output axis_tready
   );
endinterface

// File: rtl/parse_big_field_table_a2.sv
// Big-field parser: captures the first FIELD_LEN beats of each AXI-stream frame into a parallel
// register array and forwards the frame either whole (MODE "PASS") or with the field stripped
// (MODE "STRIP").
// Optional feature: define BIG_FIELD_ERR_CNT_EN to add a saturating 16-bit short-frame counter
// on output err_cnt.
module parse_big_field_table_a2 #(
   parameter int unsigned DSIZE      = 8,
   parameter int unsigned FIELD_LEN  = 128,
   parameter string       MODE       = "PASS",
   parameter string       FIELD_NAME = "Big Field"
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic                            enable,
   output logic [FIELD_LEN-1:0][DSIZE-1:0] value,
   output logic                            out_valid,
   output logic                            short_err,
`ifdef BIG_FIELD_ERR_CNT_EN
   output logic [15:0]                     err_cnt,
`endif
   axi_stream_inf.slaver                   cm_tb_s,
   axi_stream_inf.master                   cm_tb_m
);

   localparam int unsigned   CW      = $clog2(FIELD_LEN + 1);
   localparam bit            Strip   = (MODE == "STRIP");
   localparam logic [CW-1:0] LastIdx = CW'(FIELD_LEN - 1);
   localparam logic [CW-1:0] FullCnt = CW'(FIELD_LEN);

   // Elaboration-time guard on the field length range.
   if (FIELD_LEN < 1 || FIELD_LEN > 1024) begin : g_bad_field_len
      $error("%s: FIELD_LEN must be 1..1024", FIELD_NAME);
   end

   typedef enum logic [1:0] {
      StIdle,
      StField,
      StBody,
      StBypass
   } state_e;

   state_e                          state_q, state_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic [FIELD_LEN-1:0][DSIZE-1:0] value_q;
   logic                            out_valid_q;
   logic                            short_err_q;

   logic s_ready;
   logic beat;
   logic first_beat;
   logic in_field;
   logic field_beat;
   logic field_done;
   logic short_hit;

   // In IDLE, enable decides whether the arriving first beat already belongs to a field.
   assign in_field   = (state_q == StField) || ((state_q == StIdle) && enable);
   assign beat       = cm_tb_s.axis_tvalid && s_ready;
   assign first_beat = beat && (state_q == StIdle);
   assign field_beat = beat && in_field;
   assign field_done = field_beat && (cnt_q == LastIdx);
   // Frame ended with fewer than FIELD_LEN beats captured.
   assign short_hit  = field_beat && cm_tb_s.axis_tlast && (cnt_q < LastIdx);

   // Stream path: pure passthrough, except STRIP swallows field beats without back-pressure.
   always_comb begin
      cm_tb_m.axis_tdata  = cm_tb_s.axis_tdata;
      cm_tb_m.axis_tkeep  = cm_tb_s.axis_tkeep;
      cm_tb_m.axis_tlast  = cm_tb_s.axis_tlast;
      cm_tb_m.axis_tvalid = cm_tb_s.axis_tvalid;
      s_ready             = cm_tb_m.axis_tready;
      if (Strip && in_field) begin
         cm_tb_m.axis_tvalid = 1'b0;
         s_ready             = 1'b1;
      end
   end

   assign cm_tb_s.axis_tready = s_ready;

   // Next-state and beat-counter logic; the counter saturates at FIELD_LEN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (beat) begin
         if (cm_tb_s.axis_tlast) begin
            state_d = StIdle;
            cnt_d   = '0;
         end else begin
            if (cnt_q != FullCnt) begin
               cnt_d = cnt_q + CW'(1);
            end
            case (state_q)
               StIdle: begin
                  if (!enable) begin
                     state_d = StBypass;
                  end else if (field_done) begin
                     state_d = StBody;
                  end else begin
                     state_d = StField;
                  end
               end
               StField: begin
                  if (field_done) begin
                     state_d = StBody;
                  end
               end
               default: state_d = state_q;
            endcase
         end
      end
   end

   // FSM state and beat counter registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Field capture: beat at counter index i lands in value[i]; nothing is shifted.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         value_q <= '0;
      end else if (field_beat) begin
         for (int i = 0; i < int'(FIELD_LEN); i++) begin
            if (cnt_q == CW'(i)) begin
               value_q[i] <= cm_tb_s.axis_tdata;
            end
         end
      end
   end

   // Field-valid flag: completion wins over the clear when FIELD_LEN is 1.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_valid_q <= 1'b0;
      end else if (field_done) begin
         out_valid_q <= 1'b1;
      end else if (first_beat && enable) begin
         out_valid_q <= 1'b0;
      end
   end

   // Short-frame error pulse, one cycle after the offending tlast beat.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         short_err_q <= 1'b0;
      end else begin
         short_err_q <= short_hit;
      end
   end

`ifdef BIG_FIELD_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   // Saturating count of short-frame pulses.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_cnt_q <= '0;
      end else if (short_err_q && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

   assign value     = value_q;
   assign out_valid = out_valid_q;
   assign short_err = short_err_q;

endmodule

// File: tb/tb_parse_big_field_table_a2.sv
// Bench for parse_big_field_table_a2: PASS and STRIP parsers at FIELD_LEN=20 and a wide PASS
// parser at FIELD_LEN=300/DSIZE=16. Expected output beats are queued at stimulus time and
// popped by per-stream monitors.
module tb_parse_big_field_table_a2;

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   axi_stream_inf #(.DSIZE(8))  a_s ();
   axi_stream_inf #(.DSIZE(8))  a_m ();
   axi_stream_inf #(.DSIZE(8))  b_s ();
   axi_stream_inf #(.DSIZE(8))  b_m ();
   axi_stream_inf #(.DSIZE(16)) c_s ();
   axi_stream_inf #(.DSIZE(16)) c_m ();

   logic en_a, en_b, en_c;
   logic [19:0][7:0]   a_value, b_value;
   logic [299:0][15:0] c_value;
   logic a_ov, a_se, b_ov, b_se, c_ov, c_se;
`ifdef BIG_FIELD_ERR_CNT_EN
   logic [15:0] a_err, b_err, c_err;
`endif

   parse_big_field_table_a2 #(.DSIZE(8), .FIELD_LEN(20), .MODE("PASS")) dut_a (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .enable    (en_a),
      .value     (a_value),
      .out_valid (a_ov),
      .short_err (a_se),
`ifdef BIG_FIELD_ERR_CNT_EN
      .err_cnt   (a_err),
`endif
      .cm_tb_s   (a_s),
      .cm_tb_m   (a_m)
   );

   parse_big_field_table_a2 #(.DSIZE(8), .FIELD_LEN(20), .MODE("STRIP")) dut_b (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .enable    (en_b),
      .value     (b_value),
      .out_valid (b_ov),
      .short_err (b_se),
`ifdef BIG_FIELD_ERR_CNT_EN
      .err_cnt   (b_err),
`endif
      .cm_tb_s   (b_s),
      .cm_tb_m   (b_m)
   );

   parse_big_field_table_a2 #(.DSIZE(16), .FIELD_LEN(300), .MODE("PASS")) dut_c (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .enable    (en_c),
      .value     (c_value),
      .out_valid (c_ov),
      .short_err (c_se),
`ifdef BIG_FIELD_ERR_CNT_EN
      .err_cnt   (c_err),
`endif
      .cm_tb_s   (c_s),
      .cm_tb_m   (c_m)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Random back-pressure on the STRIP output while b_rand is set.
   bit b_rand = 1'b0;
   always @(negedge aclk) begin
      b_m.axis_tready = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: PASS output stream.
   always begin
      exp_t e;
      @(negedge aclk);
      #4;
      if (a_m.axis_tvalid && a_m.axis_tready) begin
         check("a_beat_expected", 64'(qa.size() != 0), 64'd1);
         if (qa.size() != 0) begin
            e = qa.pop_front();
            check("a_data", 64'(a_m.axis_tdata), 64'(e.d));
            check("a_last", 64'(a_m.axis_tlast), 64'(e.l));
         end
      end
   end

   // Monitor: STRIP output stream.
   always begin
      exp_t e;
      @(negedge aclk);
      #4;
      if (b_m.axis_tvalid && b_m.axis_tready) begin
         check("b_beat_expected", 64'(qb.size() != 0), 64'd1);
         if (qb.size() != 0) begin
            e = qb.pop_front();
            check("b_data", 64'(b_m.axis_tdata), 64'(e.d));
            check("b_last", 64'(b_m.axis_tlast), 64'(e.l));
         end
      end
   end

   // Each beat task starts at a negedge, samples the handshake 1 time unit before the posedge,
   // and returns at the negedge following acceptance.
   task automatic beat_a(input logic [7:0] d, input logic last, input logic en);
      logic hs = 1'b0;
      int   n  = 0;
      a_s.axis_tvalid = 1'b1;
      a_s.axis_tdata  = d;
      a_s.axis_tlast  = last;
      en_a            = en;
      qa.push_back('{d: d, l: last});
      while (!hs && n < 50) begin
         #4;
         hs = a_s.axis_tvalid && a_s.axis_tready;
         @(negedge aclk);
         n++;
      end
      check("a_handshake", 64'(hs), 64'd1);
      a_s.axis_tvalid = 1'b0;
      a_s.axis_tlast  = 1'b0;
   endtask

   task automatic beat_b(input logic [7:0] d, input logic last, input logic en,
                         input logic stripped);
      logic hs = 1'b0;
      int   n  = 0;
      b_s.axis_tvalid = 1'b1;
      b_s.axis_tdata  = d;
      b_s.axis_tlast  = last;
      en_b            = en;
      if (!stripped) qb.push_back('{d: d, l: last});
      while (!hs && n < 50) begin
         #4;
         if (stripped && n == 0) begin
            check("b_field_ready", 64'(b_s.axis_tready), 64'd1);
            check("b_field_no_out", 64'(b_m.axis_tvalid), 64'd0);
         end
         hs = b_s.axis_tvalid && b_s.axis_tready;
         @(negedge aclk);
         n++;
      end
      check("b_handshake", 64'(hs), 64'd1);
      b_s.axis_tvalid = 1'b0;
      b_s.axis_tlast  = 1'b0;
   endtask

   task automatic beat_c(input logic [15:0] d, input logic last, input logic en);
      logic hs = 1'b0;
      int   n  = 0;
      c_s.axis_tvalid = 1'b1;
      c_s.axis_tdata  = d;
      c_s.axis_tlast  = last;
      en_c            = en;
      while (!hs && n < 50) begin
         #4;
         hs = c_s.axis_tvalid && c_s.axis_tready;
         @(negedge aclk);
         n++;
      end
      check("c_handshake", 64'(hs), 64'd1);
      c_s.axis_tvalid = 1'b0;
      c_s.axis_tlast  = 1'b0;
   endtask

   initial begin
      a_s.axis_tvalid = 1'b0; a_s.axis_tdata = '0; a_s.axis_tkeep = '1; a_s.axis_tlast = 1'b0;
      b_s.axis_tvalid = 1'b0; b_s.axis_tdata = '0; b_s.axis_tkeep = '1; b_s.axis_tlast = 1'b0;
      c_s.axis_tvalid = 1'b0; c_s.axis_tdata = '0; c_s.axis_tkeep = '1; c_s.axis_tlast = 1'b0;
      a_m.axis_tready = 1'b1;
      c_m.axis_tready = 1'b1;
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;

      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);

      // Reset state.
      check("rst_a_value_zero", 64'(|a_value), 64'd0);
      check("rst_a_out_valid", 64'(a_ov), 64'd0);
      check("rst_a_short_err", 64'(a_se), 64'd0);
      check("rst_a_m_tvalid", 64'(a_m.axis_tvalid), 64'd0);
      check("rst_b_out_valid", 64'(b_ov), 64'd0);
      check("rst_c_out_valid", 64'(c_ov), 64'd0);
`ifdef BIG_FIELD_ERR_CNT_EN
      check("rst_a_err_cnt", 64'(a_err), 64'd0);
`endif

      // PASS: 40-beat frame 0..39.
      for (int k = 0; k < 40; k++) begin
         beat_a(8'(k), k == 39, 1'b1);
         if (k == 18) check("a_ov_before_full", 64'(a_ov), 64'd0);
         if (k == 19) check("a_ov_after_full", 64'(a_ov), 64'd1);
      end
      check("a_value0", 64'(a_value[0]), 64'd0);
      check("a_value7", 64'(a_value[7]), 64'd7);
      check("a_value19", 64'(a_value[19]), 64'd19);
      check("a_no_short_err", 64'(a_se), 64'd0);

      // PASS: short 12-beat frame 0x50..0x5B.
      for (int k = 0; k < 12; k++) begin
         beat_a(8'(8'h50 + k), k == 11, 1'b1);
         if (k == 0)  check("a_ov_cleared", 64'(a_ov), 64'd0);
         if (k == 10) check("a_se_early", 64'(a_se), 64'd0);
         if (k == 11) check("a_se_pulse", 64'(a_se), 64'd1);
      end
      @(negedge aclk);
      check("a_se_one_cycle", 64'(a_se), 64'd0);
      check("a_ov_short", 64'(a_ov), 64'd0);
      check("a_short_v0", 64'(a_value[0]), 64'h50);
      check("a_short_v11", 64'(a_value[11]), 64'h5B);
      check("a_short_v12_old", 64'(a_value[12]), 64'd12);
`ifdef BIG_FIELD_ERR_CNT_EN
      check("a_err_cnt_1", 64'(a_err), 64'd1);
`endif

      // PASS: exactly 20 beats, then a bypass frame that raises enable mid-frame.
      for (int k = 0; k < 20; k++) begin
         beat_a(8'(8'h80 + k), k == 19, 1'b1);
         if (k == 19) begin
            check("a_exact_se", 64'(a_se), 64'd0);
            check("a_exact_ov", 64'(a_ov), 64'd1);
         end
      end
      for (int k = 0; k < 5; k++) beat_a(8'(8'hC0 + k), k == 4, k != 0);
      @(negedge aclk);
      check("a_bypass_ov", 64'(a_ov), 64'd1);
      check("a_bypass_se", 64'(a_se), 64'd0);
      check("a_bypass_v0", 64'(a_value[0]), 64'h80);
      check("a_bypass_v5", 64'(a_value[5]), 64'h85);
      check("a_bypass_v19", 64'(a_value[19]), 64'h93);

      // STRIP: 40-beat frame with random output back-pressure.
      b_rand = 1'b1;
      for (int k = 0; k < 40; k++) beat_b(8'(k), k == 39, 1'b1, k < 20);
      b_rand = 1'b0;
      @(negedge aclk);
      check("b_q_drained", 64'(qb.size()), 64'd0);
      check("b_ov", 64'(b_ov), 64'd1);
      check("b_value19", 64'(b_value[19]), 64'd19);

      // STRIP: short frame produces no output and one error pulse.
      for (int k = 0; k < 12; k++) begin
         beat_b(8'(8'h50 + k), k == 11, 1'b1, 1'b1);
         if (k == 11) check("b_se_pulse", 64'(b_se), 64'd1);
      end
      @(negedge aclk);
      check("b_se_one_cycle", 64'(b_se), 64'd0);
      check("b_ov_short", 64'(b_ov), 64'd0);
      check("b_short_q_empty", 64'(qb.size()), 64'd0);
`ifdef BIG_FIELD_ERR_CNT_EN
      check("b_err_cnt_1", 64'(b_err), 64'd1);
`endif

      // Wide field: 300 beats of 16'hA000+k.
      for (int k = 0; k < 300; k++) begin
         beat_c(16'(16'hA000 + k), k == 299, 1'b1);
         if (k == 298) check("c_ov_before_full", 64'(c_ov), 64'd0);
      end
      check("c_ov", 64'(c_ov), 64'd1);
      check("c_se", 64'(c_se), 64'd0);
      check("c_v0", 64'(c_value[0]), 64'hA000);
      check("c_v150", 64'(c_value[150]), 64'hA096);
      check("c_v299", 64'(c_value[299]), 64'hA12B);

      // Asynchronous reset in the middle of a frame on the PASS parser.
      for (int k = 0; k < 10; k++) beat_a(8'(8'h10 + k), 1'b0, 1'b1);
      #2;
      aresetn = 1'b0;
      #1;
      check("mid_rst_value_zero", 64'(|a_value), 64'd0);
      check("mid_rst_ov", 64'(a_ov), 64'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      for (int k = 11; k < 40; k++) beat_a(8'(k), k == 39, 1'b1);
      check("post_rst_v0", 64'(a_value[0]), 64'd11);
      check("post_rst_v18", 64'(a_value[18]), 64'd29);
      check("post_rst_v19", 64'(a_value[19]), 64'd30);
      check("post_rst_ov", 64'(a_ov), 64'd1);

      repeat (2) @(negedge aclk);
      check("a_q_drained", 64'(qa.size()), 64'd0);
      check("b_q_final", 64'(qb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
